// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a qualified lock, then
// releases the core reset; re-sequences on lock loss and gives up after repeated timeouts.
//
// state       | meaning
// S_RST_PLL   | pll_rst held high for PLL_RST_CYCLES
// S_WAIT_LOCK | waiting for lock_s, bounded by LOCK_TIMEOUT
// S_STABLE    | lock_s must stay high for STABLE_CYCLES
// S_RUN       | core released; any lock drop restarts the sequence
// S_FAIL      | retries exhausted; left only through reset_n
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 742500,
  parameter int STABLE_CYCLES  = 4096,
  parameter int MAX_RETRIES    = 4
) (
  input  logic                               clk_74a,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic                               core_reset_n,
  output logic                               pll_ready,
  output logic                               pll_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [7:0]                         loss_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sync_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;
  logic               lock_s;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q <= S_RST_PLL;
      cnt_q   <= '0;
      sync_q  <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], pll_locked};
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // a lock arriving on the timeout cycle takes priority over the retry
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? S_FAIL : S_RST_PLL;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_RST_PLL;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RST_PLL;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign pll_rst      = (state_q == S_RST_PLL);
  assign core_reset_n = (state_q == S_RUN);
  assign pll_ready    = (state_q == S_RUN);
  assign pll_fail     = (state_q == S_FAIL);
  assign retry_cnt    = retry_q;
  assign loss_cnt     = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues the expected output
// vector and cycle of every output change; a negedge monitor pops and compares.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LTO = 100;
  localparam int STC = 16;
  localparam int MR  = 3;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .pll_ready   (pll_ready),
    .pll_fail    (pll_fail),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 clk_74a = ~clk_74a;

  int cyc = 0;
  always @(posedge clk_74a) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [13:0] val;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];

  int         total = 0;
  int         bad   = 0;
  bit         mon_en    = 1'b0;
  bit         stim_done = 1'b0;
  bit         mon_done  = 1'b0;
  bit         started   = 1'b0;
  logic [13:0] cur, prev;
  logic [7:0]  loss_exp;

  function automatic logic [13:0] ov(bit r, bit c, bit y, bit f, int rt, int ls);
    logic [1:0] rt2;
    logic [7:0] ls8;
    rt2 = rt[1:0];
    ls8 = ls[7:0];
    return {r, c, y, f, rt2, ls8};
  endfunction

  function automatic string fmt(logic [13:0] v);
    return $sformatf("rst=%b crn=%b rdy=%b fail=%b retry=%0d loss=%0d",
                     v[13], v[12], v[11], v[10], v[9:8], v[7:0]);
  endfunction

  function automatic void push(int c, logic [13:0] v, string nm);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  always @(negedge clk_74a) begin : monitor
    ev_t   e;
    string nm;
    if (mon_en) begin
      cur = {pll_rst, core_reset_n, pll_ready, pll_fail, retry_cnt, loss_cnt};
      if (!started || cur != prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change at cyc=%0d got %s", cyc, fmt(cur));
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e.cyc != cyc || e.val != cur)
          begin
            bad++;
            $display("FAIL %s: got cyc=%0d %s, want cyc=%0d %s",
                     nm, cyc, fmt(cur), e.cyc, fmt(e.val));
          end
        end
      end
      started = 1'b1;
      prev    = cur;
      if (stim_done && !mon_done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL drain: got %0d pending events, want 0 (next %s at cyc=%0d)",
                   exp_q.size(), name_q[0], exp_q[0].cyc);
        end
        mon_done = 1'b1;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick(1);
  endtask

  // lock drop of h cycles while in RUN; returns once RUN is reached again
  task automatic loss_cycle(int h);
    int c0, s;
    c0 = cyc;
    pll_locked = 1'b0;
    if (loss_exp != 8'hFF) loss_exp = loss_exp + 8'd1;
    push(c0 + 3, ov(1, 0, 0, 0, 0, loss_exp), "loss_rst");
    push(c0 + 3 + PRC, ov(0, 0, 0, 0, 0, loss_exp), "loss_pulse_end");
    s = (h + 3 > 8) ? c0 + h + 3 : c0 + 8;
    push(s + STC, ov(0, 1, 1, 0, 0, loss_exp), "relock_run");
    tick(h);
    pll_locked = 1'b1;
    wait_until(s + STC);
  endtask

  // reset with lock held low, then the first WAIT_LOCK entry
  task automatic reset_low_lock(output int d);
    d = cyc;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    push(d + 1, ov(1, 0, 0, 0, 0, 0), "reset_pulse");
    tick(1);
    reset_n = 1'b1;
    push(d + 5, ov(0, 0, 0, 0, 0, 0), "wait_entry");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c0, d;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    loss_exp   = 8'd0;

    // reset state and nominal bring-up
    push(3, ov(1, 0, 0, 0, 0, 0), "reset_state");
    tick(3);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    push(7, ov(0, 0, 0, 0, 0, 0), "first_pulse_end");
    tick(20);
    c0 = cyc;
    pll_locked = 1'b1;
    push(c0 + 19, ov(0, 1, 1, 0, 0, 0), "nominal_run");
    wait_until(c0 + 19);

    // lock loss of ~1 us, then saturation of loss_cnt
    loss_cycle(75);
    for (int i = 0; i < 300; i++) loss_cycle(5);

    // reset during STABLE, then during RUN
    c0 = cyc;
    pll_locked = 1'b0;
    push(c0 + 3, ov(1, 0, 0, 0, 0, loss_exp), "loss_before_stable");
    push(c0 + 7, ov(0, 0, 0, 0, 0, loss_exp), "wait_before_stable");
    tick(5);
    pll_locked = 1'b1;
    wait_until(c0 + 12);
    reset_n = 1'b0;
    push(c0 + 13, ov(1, 0, 0, 0, 0, 0), "reset_in_stable");
    tick(1);
    reset_n = 1'b1;
    push(c0 + 17, ov(0, 0, 0, 0, 0, 0), "wait_after_reset");
    push(c0 + 34, ov(0, 1, 1, 0, 0, 0), "run_after_reset");
    wait_until(c0 + 34);
    d = cyc;
    reset_n = 1'b0;
    push(d + 1, ov(1, 0, 0, 0, 0, 0), "reset_in_run");
    tick(1);
    reset_n = 1'b1;
    push(d + 5, ov(0, 0, 0, 0, 0, 0), "wait_after_run_reset");
    push(d + 22, ov(0, 1, 1, 0, 0, 0), "run_after_run_reset");
    wait_until(d + 22);

    // two timeouts, then lock
    reset_low_lock(d);
    push(d + 105, ov(1, 0, 0, 0, 1, 0), "retry1_pulse");
    push(d + 109, ov(0, 0, 0, 0, 1, 0), "retry1_wait");
    push(d + 209, ov(1, 0, 0, 0, 2, 0), "retry2_pulse");
    push(d + 213, ov(0, 0, 0, 0, 2, 0), "retry2_wait");
    wait_until(d + 223);
    pll_locked = 1'b1;
    push(d + 242, ov(0, 1, 1, 0, 0, 0), "retry_then_run");
    wait_until(d + 242);

    // lock drop at qualification cycle 10 with one retry already counted
    reset_low_lock(d);
    push(d + 105, ov(1, 0, 0, 0, 1, 0), "unstable_retry_pulse");
    push(d + 109, ov(0, 0, 0, 0, 1, 0), "unstable_wait");
    wait_until(d + 115);
    pll_locked = 1'b1;
    wait_until(d + 128);
    pll_locked = 1'b0;
    wait_until(d + 140);
    pll_locked = 1'b1;
    push(d + 159, ov(0, 1, 1, 0, 0, 0), "requalified_run");
    wait_until(d + 159);

    // never lock: FAIL, hold for 1000 cycles, then reset out
    reset_low_lock(d);
    push(d + 105, ov(1, 0, 0, 0, 1, 0), "fail_retry1");
    push(d + 109, ov(0, 0, 0, 0, 1, 0), "fail_wait1");
    push(d + 209, ov(1, 0, 0, 0, 2, 0), "fail_retry2");
    push(d + 213, ov(0, 0, 0, 0, 2, 0), "fail_wait2");
    push(d + 313, ov(0, 0, 0, 1, 3, 0), "fail_entry");
    wait_until(d + 1313);
    c0 = cyc;
    reset_n = 1'b0;
    push(c0 + 1, ov(1, 0, 0, 0, 0, 0), "fail_exit_reset");
    tick(1);
    reset_n = 1'b1;
    push(c0 + 5, ov(0, 0, 0, 0, 0, 0), "post_fail_wait");
    wait_until(c0 + 10);

    stim_done = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) tick(1);
    if (!mon_done) begin
      $display("FAIL monitor_done: got no drain check, want one");
      $fatal(1, "monitor stalled");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences PLL bring-up and drives the PLL's `rst` input, consuming its asynchronous `locked` output. It pulses the PLL reset and waits for lock with a timeout. Once lock has been stable for a qualification window, it releases the core reset, and it re-sequences on lock loss. The block sits in the Pocket top level between the 74.25 MHz bridge clock domain and the video/audio PLL that generates the 36 MHz and 5.142857 MHz core clocks.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: number of cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, default 742500: cycles allowed in WAIT_LOCK before a retry (10 ms at 74.25 MHz).
- `STABLE_CYCLES`, default 4096: consecutive synchronized-lock cycles required before `core_reset_n` is released.
- `MAX_RETRIES`, default 4: number of lock timeouts tolerated before FAIL (≥1).

Ports:
- `clk_74a`  in  1  free-running 74.25 MHz reference clock; sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked`, asynchronous to `clk_74a`.
- `pll_rst`  out  1  drives PLL `rst`, active high.
- `core_reset_n`  out  1  active-low reset for logic on PLL output clocks.
- `pll_ready`  out  1  high while in RUN.
- `pll_fail`  out  1  high while in FAIL.
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  timeouts since the last entry to RUN.
- `loss_cnt`  out  8  lock-loss events in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to form `lock_s`. Only `lock_s` is used internally.
- One shared cycle counter `cnt` is used, with width `$clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1)`. `cnt` clears on every state transition.
- All outputs are registered Moore decodes of the state register:
  - `pll_rst` = (state == RST_PLL)
  - `core_reset_n` = (state == RUN)
  - `pll_ready` = (state == RUN)
  - `pll_fail` = (state == FAIL)
- RST_PLL:
  - `cnt` counts up.
  - When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK.
- WAIT_LOCK:
  - If `lock_s` = 1, go to STABLE.
  - Otherwise, if `cnt == LOCK_TIMEOUT-1`:
    - `retry_cnt` increments.
    - If the incremented value equals `MAX_RETRIES`, go to FAIL; else go to RST_PLL.
  - If `lock_s` and the timeout occur in the same cycle, lock wins.
- STABLE:
  - If `lock_s` = 0, return to WAIT_LOCK. This does not count as a retry.
  - Otherwise, when `cnt == STABLE_CYCLES-1`, go to RUN and clear `retry_cnt`.
- RUN:
  - Stays while `lock_s` = 1.
  - When `lock_s` = 0, go to RST_PLL and increment `loss_cnt` (saturating).
- FAIL:
  - Terminal. `pll_rst` = 0 and `core_reset_n` = 0.
  - `retry_cnt` holds `MAX_RETRIES`.
  - Exit only via `reset_n`.
- Reset (`reset_n` = 0 at a rising edge), which also applies mid-sequence from any state:
  - state = RST_PLL, `cnt` = 0, synchronizer flops = 0.
  - `retry_cnt` = 0, `loss_cnt` = 0.
  - Resulting outputs: `pll_rst` = 1, `core_reset_n` = 0, `pll_ready` = 0, `pll_fail` = 0.

## Timing
- Synchronizer latency: a `pll_locked` edge is visible on `lock_s` 2 cycles later.
- After the first edge with `reset_n` = 1, `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles, then falls.
- WAIT_LOCK to STABLE: one edge after `lock_s` rises.
- `core_reset_n` rises exactly `STABLE_CYCLES` cycles after entering STABLE, provided `lock_s` held high throughout.
- Lock loss:
  - `pll_locked` falling in RUN drops `core_reset_n` and `pll_ready` 3 edges later (2 sync + 1 state).
  - `pll_rst` rises on that same edge.
- Lock glitches shorter than the synchronizer resolution may be missed; this is accepted.
- Timeout: `pll_rst` re-asserts on the edge after the `LOCK_TIMEOUT`th WAIT_LOCK cycle.
- No combinational paths from input to output.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=3.

1. Nominal bring-up: release `reset_n`, then raise `pll_locked` 20 cycles later.
   - `pll_rst` is high for 4 cycles.
   - `core_reset_n` rises 2+1+16 cycles after `pll_locked` rises.
   - `retry_cnt` = 0 and `pll_ready` = 1.
2. Retry then lock: hold `pll_locked` = 0 for 2 timeouts, then raise it.
   - Three 4-cycle `pll_rst` pulses occur, spaced 104 cycles apart.
   - `retry_cnt` reads 2 before RUN and 0 once RUN is reached.
3. Fail: never raise `pll_locked`.
   - After 3 timeouts, `pll_fail` = 1, `pll_rst` = 0, `retry_cnt` = 3.
   - Outputs are stable for 1000 further cycles.
   - `reset_n` pulse returns the block to RST_PLL.
4. Unstable lock: in STABLE, drop `pll_locked` at qualification cycle 10.
   - The block returns to WAIT_LOCK with `core_reset_n` still 0 and `retry_cnt` unchanged.
   - Relocking needs a full 16 cycles of qualification.
5. Lock loss in RUN: drop `pll_locked` for 1 µs.
   - `core_reset_n` falls 3 cycles later, `loss_cnt` = 1, and a new `pll_rst` 4-cycle pulse is issued.
   - 300 repeated losses leave `loss_cnt` = 255.
6. Reset mid-sequence: assert `reset_n` low for 1 cycle during STABLE and again during RUN.
   - Outputs take their reset values on the next edge: `pll_rst` = 1 and both counters = 0.
